// File: rtl/encrypt_pkg.sv
// encrypt_pkg: shared types and helpers for the streaming LWE encryptor.
//   state_e  - controller states (IDLE / ACCUM / EMIT)
//   CHUNKS   - key beats per row at the default geometry
//   ROW_W    - row index width at the default geometry
//   pt_term  - plaintext encoding (raw or scaled by q/p)
package encrypt_pkg;

  localparam int PT_W_DEF   = 6;
  localparam int CT_W_DEF   = 10;
  localparam int DIM_DEF    = 10;
  localparam int BIG_N_DEF  = 30;
  localparam int LANES_DEF  = 5;
  localparam int PT_ROW_DEF = 0;

  localparam int CHUNKS = BIG_N_DEF / LANES_DEF;
  localparam int ROW_W  = (DIM_DEF > 0) ? $clog2(DIM_DEF + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  // Returns the plaintext contribution; the caller truncates to ct_w bits.
  // With scale set the plaintext sits in the top pt_w bits (delta = q/p).
  function automatic logic [31:0] pt_term(input logic [31:0] pt,
                                          input int          pt_w,
                                          input int          ct_w,
                                          input bit          scale);
    logic [31:0] mask;
    logic [31:0] raw;
    mask = (pt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pt_w) - 32'd1);
    raw  = pt & mask;
    if (scale) return raw << (ct_w - pt_w);
    return raw;
  endfunction

endpackage

// File: rtl/lane_subset_sum.sv
// lane_subset_sum: combinational masked sum of LANES key entries.
//   entries_i - LANES packed entries, lane l at [l*W +: W]
//   mask_i    - lane l contributes when mask_i[l] is set
//   sum_o     - sum of selected entries, wrapping mod 2^W
module lane_subset_sum #(
  parameter int LANES = 5,
  parameter int W     = 10
) (
  input  logic [LANES*W-1:0] entries_i,
  input  logic [LANES-1:0]   mask_i,
  output logic [W-1:0]       sum_o
);

  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      if (mask_i[l]) sum_o = sum_o + entries_i[l*W +: W];
    end
  end

endmodule

// File: rtl/encrypt_stream.sv
// encrypt_stream: streaming LWE encryption engine.
// One public-key row arrives as CHUNKS beats of LANES entries; the
// noise-selected subset sum of the row (plus the plaintext term on row
// PT_ROW) is emitted as one ciphertext element per row, rows 0..DIMENSION.
//
// Build option: ENCRYPT_PT_SCALE_EN
//   defined   - plaintext encoded as plaintext << (CT_W - PT_W)
//   undefined - plaintext added zero-extended
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            begin encryption (honoured in IDLE only)
//   plaintext        latched on accepted start
//   noise_select     latched on accepted start, bit j selects key entry j
//   busy             high whenever not IDLE
//   key_valid/ready  key beat stream, key_data lane l at [l*CT_W +: CT_W]
//   ct_valid/ready   ciphertext element stream
//   ct_data, ct_row  element value and its row index
//   ct_last          marks row DIMENSION
//   done             one-cycle pulse after the final output handshake
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for start
// ST_ACCUM | consuming key beats of the current row
// ST_EMIT  | holding the row's ciphertext until ct_ready
module encrypt_stream
  import encrypt_pkg::*;
#(
  parameter int PLAINTEXT_WIDTH  = PT_W_DEF,
  parameter int CIPHERTEXT_WIDTH = CT_W_DEF,
  parameter int DIMENSION        = DIM_DEF,
  parameter int BIG_N            = BIG_N_DEF,
  parameter int LANES            = LANES_DEF,
  parameter int PT_ROW           = PT_ROW_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [PLAINTEXT_WIDTH-1:0]            plaintext,
  input  logic [BIG_N-1:0]                      noise_select,
  output logic                                  busy,
  input  logic                                  key_valid,
  output logic                                  key_ready,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0]     key_data,
  output logic                                  ct_valid,
  input  logic                                  ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]           ct_data,
  output logic [$clog2(DIMENSION+1)-1:0]        ct_row,
  output logic                                  ct_last,
  output logic                                  done
);

  localparam int CW       = CIPHERTEXT_WIDTH;
  localparam int PW       = PLAINTEXT_WIDTH;
  localparam int N_CHUNKS = BIG_N / LANES;
  localparam int CKW      = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int RW       = $clog2(DIMENSION + 1);

`ifdef ENCRYPT_PT_SCALE_EN
  localparam bit PT_SCALE = 1'b1;
`else
  localparam bit PT_SCALE = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CKW-1:0]      chunk_q, chunk_d;
  logic [CW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       ct_data_q, ct_data_d;
  logic [PW-1:0]       pt_q, pt_d;
  logic [BIG_N-1:0]    noise_q, noise_d;
  logic                done_q, done_d;

  logic [LANES-1:0]    lane_mask;
  logic [CW-1:0]       lane_sum;
  logic [CW-1:0]       acc_next;
  logic [CW-1:0]       pt_enc;
  logic                last_chunk;
  logic                last_row;
  logic                pt_row_hit;

  assign lane_mask = noise_q[int'(chunk_q)*LANES +: LANES];

  lane_subset_sum #(
    .LANES (LANES),
    .W     (CW)
  ) u_lane_sum (
    .entries_i (key_data),
    .mask_i    (lane_mask),
    .sum_o     (lane_sum)
  );

  assign acc_next   = acc_q + lane_sum;
  assign pt_enc     = CW'(pt_term(32'(pt_q), PW, CW, PT_SCALE));
  assign last_chunk = (chunk_q == CKW'(N_CHUNKS - 1));
  assign last_row   = (row_q == RW'(DIMENSION));
  assign pt_row_hit = (row_q == RW'(PT_ROW));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      chunk_q   <= '0;
      acc_q     <= '0;
      ct_data_q <= '0;
      pt_q      <= '0;
      noise_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      chunk_q   <= chunk_d;
      acc_q     <= acc_d;
      ct_data_q <= ct_data_d;
      pt_q      <= pt_d;
      noise_q   <= noise_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    chunk_d   = chunk_q;
    acc_d     = acc_q;
    ct_data_d = ct_data_q;
    pt_d      = pt_q;
    noise_d   = noise_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pt_d    = plaintext;
          noise_d = noise_select;
          row_d   = '0;
          chunk_d = '0;
          acc_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (key_valid) begin
          acc_d = acc_next;
          if (last_chunk) begin
            ct_data_d = acc_next + (pt_row_hit ? pt_enc : '0);
            chunk_d   = '0;
            state_d   = ST_EMIT;
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (ct_ready) begin
          if (last_row) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            acc_d   = '0;
            chunk_d = '0;
            state_d = ST_ACCUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign key_ready = (state_q == ST_ACCUM);
  assign ct_valid  = (state_q == ST_EMIT);
  assign ct_last   = ct_valid && last_row;
  assign ct_data   = ct_data_q;
  assign ct_row    = row_q;
  assign done      = done_q;

endmodule
